// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard front end: scancodes, key
// indices, receiver states and the (ext, code) -> key lookup.
package ps2_pkg;

   // Set-2 scancodes used by the two players, plus the two prefix bytes
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;

   localparam int NUM_KEYS = 10;

   // Bit positions in the held-key map
   typedef enum logic [3:0] {
      KEY_P1_DOWN  = 4'd0,
      KEY_P1_UP    = 4'd1,
      KEY_P1_RIGHT = 4'd2,
      KEY_P1_LEFT  = 4'd3,
      KEY_P1_SHOOT = 4'd4,
      KEY_P2_DOWN  = 4'd5,
      KEY_P2_UP    = 4'd6,
      KEY_P2_RIGHT = 4'd7,
      KEY_P2_LEFT  = 4'd8,
      KEY_P2_SHOOT = 4'd9
   } key_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

   // One-hot key-map mask for a decoded code; zero for unmapped codes
   function automatic logic [NUM_KEYS-1:0] key_mask(input logic ext, input logic [7:0] code);
      logic [NUM_KEYS-1:0] m;
      m = '0;
      case ({ext, code})
         {1'b0, SC_A}:     m[KEY_P1_LEFT]  = 1'b1;
         {1'b0, SC_D}:     m[KEY_P1_RIGHT] = 1'b1;
         {1'b0, SC_W}:     m[KEY_P1_UP]    = 1'b1;
         {1'b0, SC_S}:     m[KEY_P1_DOWN]  = 1'b1;
         {1'b0, SC_SPACE}: m[KEY_P1_SHOOT] = 1'b1;
         {1'b1, SC_LEFT}:  m[KEY_P2_LEFT]  = 1'b1;
         {1'b1, SC_RIGHT}: m[KEY_P2_RIGHT] = 1'b1;
         {1'b1, SC_UP}:    m[KEY_P2_UP]    = 1'b1;
         {1'b1, SC_DOWN}:  m[KEY_P2_DOWN]  = 1'b1;
         {1'b0, SC_ENTER}: m[KEY_P2_SHOOT] = 1'b1;
         default:          m = '0;
      endcase
      return m;
   endfunction

   // Opposing directions cancel: returns {a_out, b_out}
   function automatic logic [1:0] cancel_pair(input logic a, input logic b);
      return {a & ~b, b & ~a};
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: synchronises the raw lines, detects falling clock
// edges, collects start/8 data/parity/stop and drops stalled frames.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       err_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;
   logic                   ps2_clk_s;
   logic                   ps2_data_s;
   logic                   fe;

   rx_state_e              state;
   logic [2:0]             bit_cnt;
   logic [7:0]             shift;
   logic                   parity;
   logic [CNT_W-1:0]       idle_cnt;
   logic                   timeout;

   assign ps2_clk_s  = clk_sync[SYNC_STAGES-1];
   assign ps2_data_s = data_sync[SYNC_STAGES-1];
   assign fe         = clk_prev & ~ps2_clk_s;
   assign timeout    = (idle_cnt == CNT_W'(TIMEOUT_CYCLES));

   // Bring both PS/2 lines into clk_i and keep the last synced clock level
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         // NOTE: clearing the synchroniser to 0 cannot fake a falling edge, since the idle-high line only rises after reset.
         clk_sync  <= '0;
         data_sync <= '0;
         clk_prev  <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_i};
         clk_prev  <= ps2_clk_s;
      end
   end

   // Count cycles since the last falling edge while a frame is in progress
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         idle_cnt <= '0;
      end else if (fe || state == RX_IDLE) begin
         idle_cnt <= '0;
      end else if (!timeout) begin
         idle_cnt <= idle_cnt + CNT_W'(1);
      end
   end

   // Frame receiver: start, 8 data bits LSB first, odd parity, stop
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state        <= RX_IDLE;
         bit_cnt      <= '0;
         shift        <= '0;
         parity       <= 1'b0;
         byte_o       <= '0;
         byte_valid_o <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         // NOTE: default-low non-blocking assignments make the status outputs single-cycle pulses.
         byte_valid_o <= 1'b0;
         err_o        <= 1'b0;
         if (state != RX_IDLE && timeout) begin
            state <= RX_IDLE;
         end else if (fe) begin
            case (state)
               RX_IDLE: begin
                  if (!ps2_data_s) begin
                     state   <= RX_DATA;
                     bit_cnt <= '0;
                  end
               end
               RX_DATA: begin
                  shift   <= {ps2_data_s, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= RX_PARITY;
               end
               RX_PARITY: begin
                  parity <= ps2_data_s;
                  state  <= RX_STOP;
               end
               RX_STOP: begin
                  if (((^shift) ^ parity) && ps2_data_s) begin
                     byte_o       <= shift;
                     byte_valid_o <= 1'b1;
                  end else begin
                     err_o <= 1'b1;
                  end
                  state <= RX_IDLE;
               end
               default: state <= RX_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder for two players sharing one keyboard: tracks
// E0/F0 prefixes, keeps a held-key map and drives move/shoot levels.
// Optional debug outputs (last_code_o, err_count_o) exist only when
// PS2_DEBUG_EN is defined.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [3:0] player_1_move_o,
   output logic [3:0] player_2_move_o,
   output logic       player_1_shoot_o,
   output logic       player_2_shoot_o
`ifdef PS2_DEBUG_EN
   ,
   output logic [8:0] last_code_o,
   output logic [7:0] err_count_o
`endif
);

   logic [7:0]          rx_byte;
   logic                rx_valid;
   logic                rx_err;
   logic                ext;
   logic                brk;
   logic [NUM_KEYS-1:0] key_map;
   logic [NUM_KEYS-1:0] key_hit;

   ps2_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
   ) u_rx (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .ps2_clk_i   (ps2_clk_i),
      .ps2_data_i  (ps2_data_i),
      .byte_o      (rx_byte),
      .byte_valid_o(rx_valid),
      .err_o       (rx_err)
   );

   assign key_hit = key_mask(ext, rx_byte);

   // Prefix flags and held-key map, updated once per received byte
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ext     <= 1'b0;
         brk     <= 1'b0;
         key_map <= '0;
      end else if (rx_err) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (rx_valid) begin
         if (rx_byte == SC_EXT) begin
            ext <= 1'b1;
         end else if (rx_byte == SC_BRK) begin
            brk <= 1'b1;
         end else begin
            key_map <= brk ? (key_map & ~key_hit) : (key_map | key_hit);
            ext     <= 1'b0;
            brk     <= 1'b0;
         end
      end
   end

   assign player_1_move_o[3:2] = cancel_pair(key_map[KEY_P1_LEFT], key_map[KEY_P1_RIGHT]);
   assign player_1_move_o[1:0] = cancel_pair(key_map[KEY_P1_UP],   key_map[KEY_P1_DOWN]);
   assign player_2_move_o[3:2] = cancel_pair(key_map[KEY_P2_LEFT], key_map[KEY_P2_RIGHT]);
   assign player_2_move_o[1:0] = cancel_pair(key_map[KEY_P2_UP],   key_map[KEY_P2_DOWN]);
   assign player_1_shoot_o     = key_map[KEY_P1_SHOOT];
   assign player_2_shoot_o     = key_map[KEY_P2_SHOOT];

`ifdef PS2_DEBUG_EN
   // Remember the last non-prefix code and count receive errors (saturating)
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         last_code_o <= '0;
         err_count_o <= '0;
      end else begin
         if (rx_err && err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
         if (rx_valid && rx_byte != SC_EXT && rx_byte != SC_BRK) last_code_o <= {ext, rx_byte};
      end
   end
`endif

endmodule
